// File: rtl/serial_comparator_seq.sv
// rtl/serial_comparator_seq.sv - byte-serial magnitude comparator, LSB first, with l/e/g cascade.
// Optional SIGNED_MSB_EN: the final (most significant) byte is compared as signed.
module serial_comparator_seq #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       l_in,
    input  logic       e_in,
    input  logic       g_in,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       busy,
    output logic       done,
    output logic       lt,
    output logic       et,
    output logic       gt
);

    localparam int CW = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NBYTES);

    // Cascade and result encoding is one-hot {lt, eq, gt}
    localparam logic [2:0] C_LT = 3'b100;
    localparam logic [2:0] C_EQ = 3'b010;
    localparam logic [2:0] C_GT = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      casc_q, casc_d;
    logic [2:0]      res_q, res_d;
    logic            last_byte;
    logic            a_gt;
    logic            a_lt;

    assign last_byte = (cnt_q == CNT_LAST);

    always_comb begin
        a_gt = (a_byte > b_byte);
        a_lt = (a_byte < b_byte);
`ifdef SIGNED_MSB_EN
        if (last_byte) begin
            a_gt = ($signed(a_byte) > $signed(b_byte));
            a_lt = ($signed(a_byte) < $signed(b_byte));
        end
`else
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        casc_d  = casc_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    if (g_in)      casc_d = C_GT;
                    else if (l_in) casc_d = C_LT;
                    else           casc_d = C_EQ;
                end
            end
            RUN: begin
                if (byte_valid) begin
                    if (a_gt)      casc_d = C_GT;
                    else if (a_lt) casc_d = C_LT;
                    if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
                    // Result is captured on entry to DONE so it is visible alongside done
                    if (last_byte) begin
                        state_d = DONE;
                        res_d   = casc_d;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            casc_q  <= C_EQ;
            res_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
        end
    end

    assign byte_ready = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign lt         = res_q[2];
    assign et         = res_q[1];
    assign gt         = res_q[0];

endmodule

// File: tb/tb_serial_comparator_seq.sv
// tb/tb_serial_comparator_seq.sv - directed table-driven bench for serial_comparator_seq.
module tb_serial_comparator_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       l_in = 1'b0, e_in = 1'b0, g_in = 1'b0;
    logic [7:0] a_byte = 8'h00, b_byte = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready, busy, done, lt, et, gt;

    int checks = 0;
    int failures = 0;

    serial_comparator_seq #(.NBYTES(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .l_in(l_in), .e_in(e_in), .g_in(g_in),
        .a_byte(a_byte), .b_byte(b_byte), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .busy(busy), .done(done),
        .lt(lt), .et(et), .gt(gt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  lin;   // {l_in, e_in, g_in}
        logic [2:0]  res;   // {lt, et, gt}
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entry and exit: #1 after a rising edge. Start is sampled at the next edge (edge 0).
    task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] lin,
                           input int gap_at, input int gap_len, input int stray_cyc,
                           output int done_cyc, output logic [2:0] res);
        int idx;
        int gcnt;
        int cyc;
        bit got;
        bit in_gap;
        idx = 0; gcnt = 0; got = 0; done_cyc = -1; res = 3'b000;
        {l_in, e_in, g_in} = lin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        {l_in, e_in, g_in} = 3'b000;
        for (cyc = 1; cyc < 40; cyc++) begin
            in_gap = (idx == gap_at) && (gcnt < gap_len);
            start = (cyc == stray_cyc);
            if (idx < 4 && !in_gap) begin
                byte_valid = 1'b1;
                a_byte = a[idx*8 +: 8];
                b_byte = b[idx*8 +: 8];
            end else begin
                byte_valid = 1'b0;
                a_byte = 8'hA5;
                b_byte = 8'h5A;
            end
            if (in_gap) gcnt++;
            @(negedge clk);
            if (in_gap) check("gap_ready", int'(byte_ready), 1);
            if (done) begin
                got = 1;
                done_cyc = cyc;
                res = {lt, et, gt};
                break;
            end
            if (byte_valid && byte_ready) idx++;
            @(posedge clk); #1;
        end
        if (got) begin
            @(posedge clk); #1;
            start = 1'b0;
            byte_valid = 1'b0;
            @(negedge clk);
            check("post_done_done", int'(done), 0);
            check("post_done_busy", int'(busy), 0);
            check("post_done_hold", int'({lt, et, gt}), int'(res));
            @(posedge clk); #1;
        end else begin
            start = 1'b0;
            byte_valid = 1'b0;
        end
    endtask

    vec_t vecs[10];
    int dcyc;
    logic [2:0] r;
    int ndone;

    initial begin
        vecs[0] = '{32'h01020304, 32'h01020304, 3'b010, 3'b010};
        vecs[1] = '{32'h01020304, 32'h01020304, 3'b100, 3'b100};
        vecs[2] = '{32'h01020304, 32'h01020304, 3'b001, 3'b001};
        vecs[3] = '{32'h01000002, 32'h02000001, 3'b010, 3'b100};
        vecs[4] = '{32'h00000102, 32'h00000101, 3'b010, 3'b001};
`ifdef SIGNED_MSB_EN
        vecs[5] = '{32'h80000000, 32'h7F000000, 3'b010, 3'b100};
`else
        vecs[5] = '{32'h80000000, 32'h7F000000, 3'b010, 3'b001};
`endif
        vecs[6] = '{32'h12345678, 32'h12345678, 3'b000, 3'b010};
        vecs[7] = '{32'hDEADBEEF, 32'hDEADBEEF, 3'b101, 3'b001};
        vecs[8] = '{32'hDEADBEEF, 32'hDEADBEEF, 3'b110, 3'b100};
        vecs[9] = '{32'h00000000, 32'h00000001, 3'b001, 3'b100};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", int'(byte_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_res", int'({lt, et, gt}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_res", int'({lt, et, gt}), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].lin, -1, 0, -1, dcyc, r);
            check($sformatf("vec%0d_done_cycle", i), dcyc, 5);
            check($sformatf("vec%0d_result", i), int'(r), int'(vecs[i].res));
        end

        // Two-cycle valid gap after byte 2 plus a stray start during RUN
        run_cmp(32'h01020304, 32'h01020304, 3'b010, 2, 2, 3, dcyc, r);
        check("gap_done_cycle", dcyc, 7);
        check("gap_result", int'(r), 3'b010);

        // Start pulse in the DONE cycle is dropped
        run_cmp(32'h00000005, 32'h00000003, 3'b010, -1, 0, 5, dcyc, r);
        check("done_start_cycle", dcyc, 5);
        check("done_start_result", int'(r), 3'b001);

        // Reset mid-compare after two bytes
        {l_in, e_in, g_in} = 3'b010;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            byte_valid = 1'b1;
            a_byte = 8'h10;
            b_byte = 8'h20;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(byte_ready), 0);
        check("abort_res", int'({lt, et, gt}), 0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        @(posedge clk); #1;
        run_cmp(32'hFF000000, 32'hFE000000, 3'b010, -1, 0, -1, dcyc, r);
        check("fresh_done_cycle", dcyc, 5);
        check("fresh_result", int'(r), 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_comparator_seq.md
# serial_comparator_seq

Sequential multi-byte magnitude comparator that compares two NBYTES-wide operands one byte per cycle, least-significant byte first. Each byte is ranked with the same 8-bit compare-with-cascade function as the lab's comparator8. The running result feeds back as the cascade input (l/e/g) for the next, more significant byte. It sits upstream of result consumers and replaces a combinational chain of comparator8 instances when operands arrive as a byte stream.

## Interface
- NBYTES, 4, operand length in bytes (2..16)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a comparison (accepted only in IDLE)
- l_in / e_in / g_in  input  1 each  initial cascade state, latched on the start cycle
- a_byte  input  8  operand A byte; first byte is LSB
- b_byte  input  8  operand B byte; first byte is LSB
- byte_valid  input  1  a_byte/b_byte valid
- byte_ready  output  1  block accepts a byte this cycle
- busy  output  1  comparison in progress
- done  output  1  one-cycle pulse; lt/et/gt updated this cycle
- lt / et / gt  output  1 each  final result, A<B / A==B / A>B, one-hot, held until next done

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE when the NBYTES-th byte is accepted.
  - DONE→IDLE unconditionally.
- Start cycle:
  - Cascade register loads from l_in/e_in/g_in with priority g_in > l_in > e_in.
  - All-zero inputs load EQ.
  - Byte counter clears to 0.
- byte_ready = 1 only in RUN. A byte is accepted when byte_valid && byte_ready.
- Per accepted byte:
  - a_byte > b_byte → cascade = GT.
  - a_byte < b_byte → cascade = LT.
  - Equal bytes → cascade unchanged.
- Byte compares are unsigned, 8-bit. The counter is log2(NBYTES)+1 bits and never wraps; it stops at NBYTES.
- In DONE:
  - done = 1.
  - lt/et/gt register loads from the cascade state.
  - busy = 0.
- start is ignored while in RUN or DONE. A start in the DONE cycle is dropped.
- byte_valid is ignored outside RUN.
- Gaps in byte_valid stall RUN with no state change.
- Reset (any state, including mid-comparison):
  - State → IDLE, counter 0, cascade EQ.
  - No done is generated for the aborted comparison.

## Timing
- Reset values: byte_ready 0, busy 0, done 0, lt 0, et 0, gt 0. lt/et/gt stay all-zero until the first done.
- busy = 1 in RUN only.
- Start sampled at edge 0: RUN from cycle 1.
- With byte_valid held high, bytes are accepted at cycles 1..NBYTES.
- done and the new lt/et/gt appear in cycle NBYTES+1. Latency from start to done is NBYTES+1 cycles minimum, plus one cycle per byte_valid gap.
- Next start is accepted no earlier than cycle NBYTES+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SIGNED_MSB_EN defined:
  - The final (NBYTES-th, most significant) byte is compared as signed two's complement, so the full operands compare as signed.
  - All other bytes stay unsigned.
- SIGNED_MSB_EN undefined:
  - All bytes are compared unsigned; operands compare as unsigned integers.

## Test plan
- NBYTES=4, l_in/e_in/g_in=0/1/0, A=B=0x01020304 streamed LSB first → done at cycle 5 with lt/et/gt=0/1/0.
- Same equal operands with l_in/e_in/g_in=1/0/0, then again with 0/0/1 → results 1/0/0 and 0/0/1 respectively (cascade passes through).
- A=0x01000002, B=0x02000001 (LSB favours A, MSB favours B) → lt=1. A=0x00000102, B=0x00000101 → gt=1.
- Two-cycle byte_valid gap after byte 2 of an equal compare → byte_ready stays 1, done at cycle 7. A start pulse during RUN is ignored.
- Reset asserted after byte 2 → next cycle busy=0, byte_ready=0, lt/et/gt=0/0/0, no done. A fresh compare afterwards gives the correct result.
- A=0x80000000, B=0x7F000000, e_in=1 → without SIGNED_MSB_EN gt=1; with SIGNED_MSB_EN lt=1.
